// File: rtl/uart_tx_arbiter_if.sv
// Source/transmitter handshake bundle shared by the UART TX arbiter.
// slave: arbiter side; master: the game-logic sources plus the UART TX core.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] data;
  logic [NUM_REQ-1:0]   last;
  logic [NUM_REQ-1:0]   ack;
  logic [NUM_REQ-1:0]   grant;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;

  modport slave (
    input  req, data, last, tx_busy,
    output ack, grant, tx_data, tx_start
  );

  modport master (
    output req, data, last, tx_busy,
    input  ack, grant, tx_data, tx_start
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART transmitter between
// several byte-stream sources; grants are held until the packet's last byte.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned IDLE_TIMEOUT = 4096
) (
  input logic          clk,
  input logic          rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW = $clog2(IDLE_TIMEOUT);
  localparam int unsigned AW = 2;
  localparam logic [AW-1:0] ACC_LAST = AW'(3);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACC,
    WAIT_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        rr, rr_nxt;
  logic [TW-1:0]        to_cnt, to_cnt_nxt;
  logic [AW-1:0]        acc_cnt, acc_cnt_nxt;
  logic                 pkt_end, pkt_end_nxt;
  logic [NUM_REQ-1:0]   grant_q, grant_nxt;
  logic [NUM_REQ-1:0]   ack_q, ack_nxt;
  logic [7:0]           tx_data_q, tx_data_nxt;
  logic                 tx_start_q, tx_start_nxt;

  logic [7:0]           src_data [NUM_REQ];
  logic                 cur_req;
  logic                 cur_last;
  logic [7:0]           cur_data;
  logic                 pick_found;
  logic [IW-1:0]        pick_idx;
  logic [IW-1:0]        cand;

  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_slice
    assign src_data[i] = bus.data[8*i +: 8];
  end

  // rr always holds the current (or most recent) owner
  assign cur_req  = bus.req[rr];
  assign cur_last = bus.last[rr];
  assign cur_data = src_data[rr];

  assign bus.grant    = grant_q;
  assign bus.ack      = ack_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;

  // First requester after the previous winner, wrapping modulo NUM_REQ
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr;
    cand       = rr;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      cand = (cand == IW'(NUM_REQ - 1)) ? '0 : cand + IW'(1);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr         <= IW'(NUM_REQ - 1);
      to_cnt     <= '0;
      acc_cnt    <= '0;
      pkt_end    <= 1'b0;
      grant_q    <= '0;
      ack_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr         <= rr_nxt;
      to_cnt     <= to_cnt_nxt;
      acc_cnt    <= acc_cnt_nxt;
      pkt_end    <= pkt_end_nxt;
      grant_q    <= grant_nxt;
      ack_q      <= ack_nxt;
      tx_data_q  <= tx_data_nxt;
      tx_start_q <= tx_start_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rr_nxt       = rr;
    to_cnt_nxt   = to_cnt;
    acc_cnt_nxt  = '0;
    pkt_end_nxt  = pkt_end;
    grant_nxt    = grant_q;
    ack_nxt      = '0;
    tx_data_nxt  = tx_data_q;
    tx_start_nxt = 1'b0;

    case (state)
      IDLE: begin
        to_cnt_nxt = '0;
        if (pick_found) begin
          grant_nxt = NUM_REQ'(1) << pick_idx;
          rr_nxt    = pick_idx;
          state_nxt = SEND;
        end
      end

      SEND: begin
        if (cur_req) begin
          to_cnt_nxt = '0;
          if (!bus.tx_busy) begin
            tx_start_nxt = 1'b1;
            tx_data_nxt  = cur_data;
            ack_nxt      = NUM_REQ'(1) << rr;
            pkt_end_nxt  = cur_last;
            state_nxt    = WAIT_ACC;
          end
        end else if (to_cnt == TW'(IDLE_TIMEOUT - 1)) begin
          // source stalled mid-packet for too long: abandon the packet
          to_cnt_nxt = '0;
          grant_nxt  = '0;
          state_nxt  = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + TW'(1);
        end
      end

      WAIT_ACC: begin
        // a TX core that finishes before busy is seen must not deadlock us
        if (bus.tx_busy || acc_cnt == ACC_LAST) begin
          state_nxt = WAIT_DONE;
        end else begin
          acc_cnt_nxt = acc_cnt + AW'(1);
        end
      end

      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (pkt_end) begin
            grant_nxt = '0;
            state_nxt = IDLE;
          end else begin
            state_nxt = SEND;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte-stream sources, a UART busy model
// and a start/ack monitor driven from one linear stimulus sequence.
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int TO = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .IDLE_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int viol  = 0;

  logic [7:0]   sb [N][16];
  bit           sl [N][16];
  int           slen [N];
  int           spos [N];
  bit           sen  [N];
  int           ack_cnt [N];

  logic [7:0]   lb [256];
  logic [N-1:0] lo [256];
  int           log_n;

  int           busy_cnt;
  int           busy_len;
  bit           rand_busy;
  logic [N-1:0] prev_grant;
  bit           pkt_open;
  logic [N-1:0] open_owner;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] g);
    for (int i = 0; i < N; i++)
      if (((g >> i) & N'(1)) != '0) return i;
    return 0;
  endfunction

  task automatic push(input int s, input logic [7:0] b, input bit l);
    sb[s][slen[s]] = b;
    sl[s][slen[s]] = l;
    slen[s]++;
  endtask

  // Present each source's current byte; idle sources show junk data/last
  task automatic drive_src();
    logic [N-1:0]   r;
    logic [N-1:0]   l;
    logic [8*N-1:0] d;
    r = '0; l = '0; d = '0;
    for (int i = 0; i < N; i++) begin
      logic [7:0] b;
      bit         lf;
      if (sen[i] && spos[i] < slen[i]) begin
        r  = r | (N'(1) << i);
        b  = sb[i][spos[i]];
        lf = sl[i][spos[i]];
      end else begin
        b  = 8'($urandom);
        lf = 1'($urandom);
      end
      d = d | ((8*N)'(b) << (8*i));
      if (lf) l = l | (N'(1) << i);
    end
    bus.req  = r;
    bus.data = d;
    bus.last = l;
  endtask

  // One clock: check protocol on pre-edge values, then advance sources/UART
  task automatic tick();
    logic         st;
    logic [7:0]   td;
    logic [N-1:0] g;
    logic [N-1:0] a;
    logic         bsy;
    int           o;
    st = bus.tx_start; td = bus.tx_data; g = bus.grant; a = bus.ack; bsy = bus.tx_busy;
    if (st && bsy) viol++;
    if ((a & ~g) != '0) viol++;
    if ($countones(a) > 1) viol++;
    if ((a != '0) != st) viol++;
    if ($countones(g) > 1) viol++;
    if (prev_grant != '0 && g != '0 && g != prev_grant) viol++;
    prev_grant = g;
    if (st) begin
      if (g == '0) viol++;
      if (pkt_open && g != open_owner) viol++;
      o = oh2i(g);
      if (log_n < 256) begin
        lb[log_n] = td;
        lo[log_n] = g;
      end
      log_n++;
      pkt_open   = !(spos[o] < slen[o] && sl[o][spos[o]]);
      open_owner = g;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (((a >> i) & N'(1)) != '0) begin
        ack_cnt[i]++;
        if (spos[i] < slen[i]) spos[i]++;
      end
    end
    if (busy_cnt > 0) busy_cnt--;
    if (st) busy_cnt = rand_busy ? int'($urandom_range(1, 20)) : busy_len;
    bus.tx_busy = (busy_cnt != 0);
    drive_src();
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      slen[i] = 0; spos[i] = 0; sen[i] = 1'b0; ack_cnt[i] = 0;
    end
    pkt_open = 1'b0;
  endtask

  task automatic rst_begin();
    rst_n = 1'b0;
    clear_src();
    log_n = 0; viol = 0; prev_grant = '0; open_owner = '0;
    busy_cnt = 0; rand_busy = 1'b0; bus.tx_busy = 1'b0;
    drive_src();
  endtask

  task automatic rst_end();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic bit drained();
    for (int i = 0; i < N; i++)
      if (spos[i] < slen[i]) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    int n;
    int mm;
    int exp_n;
    int k [N];

    // 1: single source, "OK\n", 10-clock frames
    rst_begin();
    busy_len = 10;
    rst_end();
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_ack", 32'(bus.ack), 32'h0);
    chk("rst_tx_start", 32'(bus.tx_start), 32'h0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'h0);
    push(0, 8'h4F, 1'b0); push(0, 8'h4B, 1'b0); push(0, 8'h0A, 1'b1);
    sen[0] = 1'b1;
    drive_src();
    for (int c = 0; c < 300 && log_n < 3; c++) tick();
    chk("t1_starts", 32'(log_n), 32'd3);
    for (int c = 0; c < 50 && bus.tx_busy; c++) tick();
    chk("t1_grant_held", 32'(bus.grant), 32'h1);
    tick();
    chk("t1_grant_rel", 32'(bus.grant), 32'h0);
    chk("t1_byte0", 32'(lb[0]), 32'h4F);
    chk("t1_byte1", 32'(lb[1]), 32'h4B);
    chk("t1_byte2", 32'(lb[2]), 32'h0A);
    chk("t1_ack0_cnt", 32'(ack_cnt[0]), 32'd3);
    chk("t1_protocol", 32'(viol), 32'd0);

    // 2: all three requesting from reset, 1-byte packets
    rst_begin();
    busy_len = 3;
    push(0, "a", 1'b1); push(0, "d", 1'b1);
    push(1, "b", 1'b1); push(1, "e", 1'b1);
    push(2, "c", 1'b1); push(2, "f", 1'b1);
    for (int i = 0; i < N; i++) sen[i] = 1'b1;
    rst_end();
    for (int c = 0; c < 400 && log_n < 4; c++) tick();
    chk("t2_starts", 32'(log_n >= 4), 32'd1);
    chk("t2_own0", 32'(lo[0]), 32'h1);
    chk("t2_own1", 32'(lo[1]), 32'h2);
    chk("t2_own2", 32'(lo[2]), 32'h4);
    chk("t2_own3", 32'(lo[3]), 32'h1);
    chk("t2_bytes", {lb[0], lb[1], lb[2], lb[3]}, {8'h61, 8'h62, 8'h63, 8'h64});
    chk("t2_protocol", 32'(viol), 32'd0);

    // 3: req0 rises while req1 is mid-packet
    rst_begin();
    busy_len = 4;
    push(1, "x", 1'b0); push(1, "y", 1'b0); push(1, "z", 1'b1);
    sen[1] = 1'b1;
    rst_end();
    for (int c = 0; c < 100 && ack_cnt[1] < 1; c++) tick();
    push(0, "w", 1'b1);
    sen[0] = 1'b1;
    drive_src();
    for (int c = 0; c < 400 && log_n < 4; c++) tick();
    chk("t3_starts", 32'(log_n), 32'd4);
    chk("t3_own", {29'd0, lo[0] & lo[1] & lo[2]}, 32'h2);
    chk("t3_own_next", 32'(lo[3]), 32'h1);
    chk("t3_bytes", {lb[0], lb[1], lb[2], lb[3]}, {8'h78, 8'h79, 8'h7A, 8'h77});
    chk("t3_ack0_cnt", 32'(ack_cnt[0]), 32'd1);
    chk("t3_protocol", 32'(viol), 32'd0);

    // 4: req2 stalls after a non-last byte; grant held IDLE_TIMEOUT SEND cycles
    rst_begin();
    busy_len = 3;
    push(2, "Z", 1'b0);
    sen[2] = 1'b1;
    rst_end();
    for (int c = 0; c < 100 && log_n < 1; c++) tick();
    chk("t4_first_start", 32'(log_n), 32'd1);
    for (int c = 0; c < 50 && bus.tx_busy; c++) tick();
    tick();
    n = 0;
    while (bus.grant == 3'b100 && n < TO + 100) begin
      n++;
      tick();
    end
    chk("t4_hold_clks", 32'(n), 32'(TO));
    chk("t4_grant_rel", 32'(bus.grant), 32'h0);
    chk("t4_no_start", 32'(log_n), 32'd1);

    // 5: asynchronous reset while in WAIT_DONE
    rst_begin();
    busy_len = 10;
    push(1, "P", 1'b0); push(1, "Q", 1'b1);
    sen[1] = 1'b1;
    rst_end();
    for (int c = 0; c < 100 && log_n < 1; c++) tick();
    tick();
    chk("t5_pre_grant", 32'(bus.grant), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_grant", 32'(bus.grant), 32'h0);
    chk("t5_async_ack", 32'(bus.ack), 32'h0);
    chk("t5_async_start", 32'(bus.tx_start), 32'h0);
    clear_src();
    push(1, "R", 1'b1);
    push(0, "S", 1'b1);
    sen[0] = 1'b1; sen[1] = 1'b1;
    drive_src();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_first_grant", 32'(bus.grant), 32'h1);
    for (int c = 0; c < 400 && log_n < 3; c++) tick();
    chk("t5_starts", 32'(log_n), 32'd3);
    chk("t5_byte1", {24'd0, lb[1]}, 32'h53);
    chk("t5_own1", 32'(lo[1]), 32'h1);
    chk("t5_byte2", {24'd0, lb[2]}, 32'h52);
    chk("t5_own2", 32'(lo[2]), 32'h2);

    // 6: random packets and frame lengths
    rst_begin();
    exp_n = 0;
    for (int s = 0; s < N; s++) begin
      int np;
      np = int'($urandom_range(1, 3));
      for (int p = 0; p < np; p++) begin
        int len;
        len = int'($urandom_range(1, 4));
        for (int b = 0; b < len; b++) push(s, 8'($urandom), b == len - 1);
        exp_n += len;
      end
      sen[s] = 1'b1;
    end
    rand_busy = 1'b1;
    rst_end();
    for (int c = 0; c < 20000 && !(drained() && !bus.tx_busy && bus.grant == '0); c++) tick();
    chk("t6_starts", 32'(log_n), 32'(exp_n));
    mm = 0;
    for (int i = 0; i < N; i++) k[i] = 0;
    for (int e = 0; e < log_n && e < 256; e++) begin
      int o;
      o = oh2i(lo[e]);
      if (k[o] >= slen[o] || lb[e] !== sb[o][k[o]]) mm++;
      k[o]++;
    end
    chk("t6_stream", 32'(mm), 32'd0);
    for (int s = 0; s < N; s++) chk("t6_src_bytes", 32'(k[s]), 32'(slen[s]));
    chk("t6_protocol", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
